// File: rtl/tanh_bp.sv
// Backward pass of the four-region piecewise-linear tanh: d = g * f'(x).
// Two-stage valid/ready pipeline with per-vector element indexing and an end-of-vector pulse.
module tanh_bp #(
  parameter int WIDTH = 24,
  parameter int LEN   = 16,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_g,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_d,
  output logic             o_last,
  output logic             o_done,
  output logic [CW-1:0]    o_idx
);

  // Region thresholds on |x| in 20-fractional-bit fixed point: 0.5, 1.0, 2.0.
  localparam logic [WIDTH-1:0] TH_R1 = WIDTH'(32'h0008_0000);
  localparam logic [WIDTH-1:0] TH_R2 = WIDTH'(32'h0010_0000);
  localparam logic [WIDTH-1:0] TH_R3 = WIDTH'(32'h0020_0000);

  logic             en;
  logic             in_xfer;
  logic [CW-1:0]    cnt_reg;
  logic             cnt_last;

  logic             s1_valid_reg;
  logic             s1_last_reg;
  logic [1:0]       s1_region_reg;
  logic [WIDTH-1:0] s1_g_reg;
  logic [CW-1:0]    s1_idx_reg;

  logic [WIDTH-1:0] mag;
  logic [1:0]       region_next;
  logic [WIDTH-1:0] d_next;
  logic [WIDTH-1:0] g_shift [3];

  logic             o_valid_reg;
  logic             o_last_reg;
  logic             o_done_reg;
  logic [WIDTH-1:0] o_d_reg;
  logic [CW-1:0]    o_idx_reg;

  assign en       = ~o_valid_reg | i_ready;
  assign o_ready  = en;
  assign in_xfer  = i_valid & en;
  assign cnt_last = (cnt_reg == CW'(LEN - 1));

  // Magnitude is compared unsigned, so the most negative x lands in the flat region.
  always_comb begin
    mag         = i_x[WIDTH-1] ? (~i_x + WIDTH'(1)) : i_x;
    region_next = 2'd3;
    if (mag < TH_R1)
      region_next = 2'd0;
    else if (mag < TH_R2)
      region_next = 2'd1;
    else if (mag < TH_R3)
      region_next = 2'd2;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_slope
    assign g_shift[gi] = $signed(s1_g_reg) >>> gi;
  end

  always_comb begin
    d_next = '0;
    case (s1_region_reg)
      2'd0:    d_next = g_shift[0];
      2'd1:    d_next = g_shift[1];
      2'd2:    d_next = g_shift[2];
      default: d_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_reg <= '0;
    else if (in_xfer)
      cnt_reg <= cnt_last ? '0 : cnt_reg + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_region_reg <= 2'd0;
      s1_g_reg      <= '0;
      s1_idx_reg    <= '0;
    end else if (en) begin
      s1_valid_reg <= i_valid;
      if (i_valid) begin
        s1_last_reg   <= cnt_last;
        s1_region_reg <= region_next;
        s1_g_reg      <= i_g;
        s1_idx_reg    <= cnt_reg;
      end
    end
  end

  // Output data only moves with a real element, so o_d holds through bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid_reg <= 1'b0;
      o_last_reg  <= 1'b0;
      o_done_reg  <= 1'b0;
      o_d_reg     <= '0;
      o_idx_reg   <= '0;
    end else begin
      o_done_reg <= o_valid_reg & i_ready & o_last_reg;
      if (en) begin
        o_valid_reg <= s1_valid_reg;
        o_last_reg  <= s1_valid_reg & s1_last_reg;
        if (s1_valid_reg) begin
          o_d_reg   <= d_next;
          o_idx_reg <= s1_idx_reg;
        end
      end
    end
  end

  assign o_valid = o_valid_reg;
  assign o_last  = o_last_reg;
  assign o_done  = o_done_reg;
  assign o_d     = o_d_reg;
  assign o_idx   = o_idx_reg;

endmodule

// File: doc/tanh_bp.md
Name: tanh_bp

Overview:
- Backward-pass companion to the forward piecewise-linear tanh activation in the LSTM datapath.
- Consumes a stream of (pre-activation x, upstream gradient g) pairs and produces the local gradient d = g * f'(x), where f' is the derivative of the same four-region PWL tanh.
- Two-stage valid/ready pipeline with an element counter that marks the end of each LEN-element vector, so the backprop sequencer knows when a gate's delta vector is complete.

Parameters:
- WIDTH, 24, data width; two's complement fixed point, 20 fractional bits (0x100000 = 1.0).
- LEN, 16, elements per vector; LEN >= 1.
- CW, 8, element counter width; 2^CW >= LEN.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- i_valid  input  1  upstream presents x/g
- o_ready  output  1  block accepts x/g this cycle
- i_x  input  WIDTH  pre-activation x
- i_g  input  WIDTH  upstream gradient g
- o_valid  output  1  o_d valid
- i_ready  input  1  downstream accepts o_d
- o_d  output  WIDTH  local gradient
- o_last  output  1  o_d is element LEN-1 of its vector
- o_done  output  1  one-cycle pulse when the last element transfers
- o_idx  output  CW  index of the element currently on o_d

Behaviour:
- Reset (rst_n=0 at clk edge): stage valids, o_valid, o_last, o_done, o_d, o_idx and the input counter all go to 0. This applies mid-vector too: in-flight data is discarded and the next accepted element is index 0.
- Pipeline enable: en = ~o_valid | i_ready. o_ready = en (combinational). An input transfers when i_valid & o_ready.
- Stage 1 (on en):
  - Registers valid, g, index and last (index == LEN-1).
  - Registers a 2-bit region code from p = |x|, computed as the two's complement magnitude and compared UNSIGNED:
    - p < 0x080000 -> R0 (slope 1)
    - p < 0x100000 -> R1 (slope 1/2)
    - p < 0x200000 -> R2 (slope 1/4)
    - otherwise -> R3 (slope 0)
  - Exact boundaries fall in the upper region: |x| = 0.5 -> R1, 1.0 -> R2, 2.0 -> R3.
  - x = 0x800000 (magnitude wraps to 0x800000) -> R3.
- Stage 2 (on en):
  - d = g for R0, g>>>1 for R1, g>>>2 for R2, 0 for R3.
  - Shifts are arithmetic (sign-preserving) and truncate toward -inf. No rounding; no overflow is possible.
  - Registers o_d, o_valid, o_last and o_idx from stage 1.
- Latency: 2 cycles from input transfer to o_valid with no backpressure. Throughput is 1 per cycle.
- Stall (o_valid & ~i_ready):
  - Both stages hold and o_ready = 0.
  - o_d, o_last and o_idx remain stable until transfer.
  - Bubbles in stage 1 are not compressed during a stall. This is acceptable.
- Counter:
  - Increments on each input transfer.
  - Wraps from LEN-1 to 0 (LEN = 1: always 0, every element is last).
  - Back-to-back vectors need no idle cycle.
- o_done: o_valid & i_ready & o_last, registered. It asserts the cycle after the last element's transfer, for exactly one cycle.
- Simultaneous input transfer and output transfer in one cycle is normal streaming and loses nothing.
- o_d when o_valid = 0 is don't-care for consumers but must be deterministic: hold the last value, 0 after reset.

Test Plan:
- Region sweep, i_ready=1: each pair applied with g=0x100000, and each must give its o_d 2 cycles later.
  - x=0x040000 -> 0x100000
  - x=0x080000 -> 0x080000
  - x=0xF00000 -> 0x040000
  - x=0x200000 -> 0x000000
  - x=0x800000 -> 0x000000
- Negative gradient rounding:
  - x=0x0C0000, g=0xFFFFFF -> o_d=0xFFFFFF
  - x=0x180000, g=0xFFFFF8 -> o_d=0xFFFFFE
- Backpressure: stream 6 elements with i_ready toggling 1,0,0,1 and random i_valid gaps. Required response:
  - o_ready=0 whenever o_valid & ~i_ready.
  - Output sequence is identical to the no-stall run, with no drop or duplicate.
  - o_d stays stable while stalled.
- Vector framing, LEN=4: 9 back-to-back inputs. Required response:
  - o_idx = 0,1,2,3,0,1,2,3,0.
  - o_last high on elements 3 and 7.
  - o_done pulses one cycle after each of those transfers.
  - Also check LEN=1: o_last is high on every output.
- Reset mid-stream: rst_n=0 for 1 cycle while both stages are full at index 2. Required response:
  - Next cycle o_valid=0, o_d=0, o_idx=0.
  - The next accepted input is reported as o_idx=0.
- Continuous throughput: 32 consecutive transfers with i_valid=i_ready=1 -> o_valid high every cycle from cycle 2 onward, and 32 outputs in 34 cycles.
